// File: rtl/instruction_packer.sv
// Packs decoded R/I/J/NOP field tuples into 32-bit MIPS words and writes them to consecutive
// instruction-memory addresses until HALT or full. Optional checksum: define INSTR_PACKER_CHECKSUM_EN.
module instruction_packer #(
  parameter int unsigned           NB_DATA      = 32,
  parameter int unsigned           NB_OP        = 6,
  parameter int unsigned           NB_FUNCT     = 6,
  parameter int unsigned           NB_INM       = 16,
  parameter int unsigned           NB_REG       = 5,
  parameter int unsigned           NB_DIRECTION = 26,
  parameter int unsigned           NB_ADDR      = 8,
  parameter logic [NB_OP-1:0]      HALT_OP      = 6'h3F
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              fmt,
  input  logic [NB_OP-1:0]        operation,
  input  logic [NB_FUNCT-1:0]     funct,
  input  logic [NB_REG-1:0]       shamt,
  input  logic [NB_REG-1:0]       wire_A,
  input  logic [NB_REG-1:0]       wire_B,
  input  logic [NB_REG-1:0]       wire_dest,
  input  logic [NB_INM-1:0]       inmediate,
  input  logic [NB_DIRECTION-1:0] direction,
  output logic                    mem_we,
  output logic [NB_ADDR-1:0]      mem_addr,
  output logic [NB_DATA-1:0]      mem_data,
  output logic [NB_ADDR:0]        word_count,
  output logic                    done,
  output logic                    full,
  output logic [NB_DATA-1:0]      checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]         FMT_R     = 2'd0;
  localparam logic [1:0]         FMT_I     = 2'd1;
  localparam logic [1:0]         FMT_J     = 2'd2;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};
  localparam logic [NB_ADDR-1:0] PTR_ONE   = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0]   WC_ONE    = {{NB_ADDR{1'b0}}, 1'b1};

  function automatic logic [NB_DATA-1:0] pack_word(
    input logic [1:0]              f,
    input logic [NB_OP-1:0]        op,
    input logic [NB_REG-1:0]       rs,
    input logic [NB_REG-1:0]       rt,
    input logic [NB_REG-1:0]       rd,
    input logic [NB_REG-1:0]       sh,
    input logic [NB_FUNCT-1:0]     fn,
    input logic [NB_INM-1:0]       imm,
    input logic [NB_DIRECTION-1:0] dir
  );
    logic [NB_DATA-1:0] w;
    case (f)
      FMT_R:   w = {op, rs, rt, rd, sh, fn};
      FMT_I:   w = {op, rs, rt, imm};
      FMT_J:   w = {op, dir};
      default: w = {NB_DATA{1'b0}};
    endcase
    return w;
  endfunction

  state_t               state_q, state_d;
  logic [NB_ADDR-1:0]   ptr_q, ptr_d;
  logic                 in_ready_q, in_ready_d;
  logic                 mem_we_q, mem_we_d;
  logic [NB_ADDR-1:0]   mem_addr_q, mem_addr_d;
  logic [NB_DATA-1:0]   mem_data_q, mem_data_d;
  logic [NB_ADDR:0]     word_count_q, word_count_d;
  logic                 done_q, done_d;
  logic                 full_q, full_d;
  logic                 accept_s;
  logic                 halt_s;
  logic [NB_DATA-1:0]   word_s;

  assign word_s = pack_word(fmt, operation, wire_A, wire_B, wire_dest, shamt, funct,
                            inmediate, direction);
  // NOP never terminates, even when the opcode field happens to equal HALT_OP.
  assign halt_s = (operation == HALT_OP) && (fmt != 2'd3);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    full_d       = full_q;
    accept_s     = 1'b0;
    if (start) begin
      // Start wins over any tuple presented in the same cycle.
      state_d      = S_LOAD;
      ptr_d        = {NB_ADDR{1'b0}};
      word_count_d = {(NB_ADDR+1){1'b0}};
      done_d       = 1'b0;
      full_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LOAD: begin
          if (in_valid) begin
            accept_s     = 1'b1;
            mem_we_d     = 1'b1;
            mem_addr_d   = ptr_q;
            mem_data_d   = word_s;
            ptr_d        = ptr_q + PTR_ONE;
            word_count_d = word_count_q + WC_ONE;
            if (ptr_q == LAST_ADDR) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              full_d  = 1'b1;
            end else if (halt_s) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
    in_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= {NB_ADDR{1'b0}};
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {NB_ADDR{1'b0}};
      mem_data_q   <= {NB_DATA{1'b0}};
      word_count_q <= {(NB_ADDR+1){1'b0}};
      done_q       <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      full_q       <= full_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign word_count = word_count_q;
  assign done       = done_q;
  assign full       = full_q;

`ifdef INSTR_PACKER_CHECKSUM_EN
  logic [NB_DATA-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start) begin
      checksum_d = {NB_DATA{1'b0}};
    end else if (accept_s) begin
      checksum_d = checksum_q ^ word_s;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Running XOR tracks mem_data, updating on the same edge as mem_we.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum_q <= {NB_DATA{1'b0}};
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = {NB_DATA{1'b0}};
`endif

endmodule

// File: tb/tb_instruction_packer.sv
// Directed self-checking bench for instruction_packer, built with a 4-word memory (NB_ADDR=2).
module tb_instruction_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  operation;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [4:0]  wire_A;
  logic [4:0]  wire_B;
  logic [4:0]  wire_dest;
  logic [15:0] inmediate;
  logic [25:0] direction;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [31:0] mem_data;
  logic [2:0]  word_count;
  logic        done;
  logic        full;
  logic [31:0] checksum;

  int tests = 0;
  int fails = 0;

  instruction_packer #(.NB_ADDR(2)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .operation(operation), .funct(funct), .shamt(shamt), .wire_A(wire_A),
    .wire_B(wire_B), .wire_dest(wire_dest), .inmediate(inmediate), .direction(direction),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .word_count(word_count),
    .done(done), .full(full), .checksum(checksum)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    fmt = 2'd0; operation = op; wire_A = rs; wire_B = rt; wire_dest = rd; shamt = sh; funct = fn;
    in_valid = 1'b1;
  endtask

  task automatic drive_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm);
    fmt = 2'd1; operation = op; wire_A = rs; wire_B = rt; inmediate = imm;
    in_valid = 1'b1;
  endtask

  task automatic drive_j(input logic [5:0] op, input logic [25:0] dir);
    fmt = 2'd2; operation = op; direction = dir;
    in_valid = 1'b1;
  endtask

  task automatic check_cs(input string tag, input logic [31:0] exp_en);
`ifdef INSTR_PACKER_CHECKSUM_EN
    chk(tag, {32'h0, checksum}, {32'h0, exp_en});
`else
    chk(tag, {32'h0, checksum}, 64'h0);
`endif
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; fmt = 2'd0; operation = 6'h00;
    funct = 6'h00; shamt = 5'd0; wire_A = 5'd0; wire_B = 5'd0; wire_dest = 5'd0;
    inmediate = 16'h0000; direction = 26'h0;
    tick(); tick();
    chk("rst_in_ready", {63'h0, in_ready}, 64'd0);
    chk("rst_mem_we",   {63'h0, mem_we},   64'd0);
    chk("rst_addr",     {62'h0, mem_addr}, 64'd0);
    chk("rst_data",     {32'h0, mem_data}, 64'd0);
    chk("rst_wc",       {61'h0, word_count}, 64'd0);
    chk("rst_done",     {63'h0, done}, 64'd0);
    chk("rst_full",     {63'h0, full}, 64'd0);
    check_cs("rst_checksum", 32'h0);
    reset = 1'b1;
    tick();
    chk("idle_no_ready", {63'h0, in_ready}, 64'd0);

    // R word then HALT J word
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_ready", {63'h0, in_ready}, 64'd1);
    drive_r(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20); tick();
    chk("t1_we0",   {63'h0, mem_we}, 64'd1);
    chk("t1_addr0", {62'h0, mem_addr}, 64'd0);
    chk("t1_data0", {32'h0, mem_data}, 64'h00221820);
    chk("t1_wc1",   {61'h0, word_count}, 64'd1);
    drive_j(6'h3F, 26'h0); tick(); in_valid = 1'b0;
    chk("t1_we1",   {63'h0, mem_we}, 64'd1);
    chk("t1_addr1", {62'h0, mem_addr}, 64'd1);
    chk("t1_data1", {32'h0, mem_data}, 64'hFC000000);
    chk("t1_wc2",   {61'h0, word_count}, 64'd2);
    chk("t1_done",  {63'h0, done}, 64'd1);
    chk("t1_full",  {63'h0, full}, 64'd0);
    chk("t1_ready_drop", {63'h0, in_ready}, 64'd0);
    check_cs("t1_checksum", 32'hFC221820);
    tick();
    chk("t1_we_pulse", {63'h0, mem_we}, 64'd0);
    chk("t1_done_hold", {63'h0, done}, 64'd1);

    // I word streamed for three cycles
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_done_clr", {63'h0, done}, 64'd0);
    chk("t2_wc_clr", {61'h0, word_count}, 64'd0);
    check_cs("t2_cs_clr", 32'h0);
    drive_i(6'h08, 5'd4, 5'd5, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_we",   {63'h0, mem_we}, 64'd1);
      chk("t2_addr", {62'h0, mem_addr}, 64'(i));
      chk("t2_data", {32'h0, mem_data}, 64'h2085FFFF);
      chk("t2_wc",   {61'h0, word_count}, 64'(i + 1));
    end
    in_valid = 1'b0; tick();
    chk("t2_idle_we", {63'h0, mem_we}, 64'd0);
    check_cs("t2_checksum", 32'h2085FFFF);

    // fill all four addresses
    start = 1'b1; tick(); start = 1'b0;
    drive_r(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_addr", {62'h0, mem_addr}, 64'(i));
    end
    chk("t3_wc4",   {61'h0, word_count}, 64'd4);
    chk("t3_done",  {63'h0, done}, 64'd1);
    chk("t3_full",  {63'h0, full}, 64'd1);
    chk("t3_ready", {63'h0, in_ready}, 64'd0);
    tick();
    chk("t3_fifth_we", {63'h0, mem_we}, 64'd0);
    chk("t3_fifth_wc", {61'h0, word_count}, 64'd4);
    in_valid = 1'b0;

    // start collides with third tuple
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_full_clr", {63'h0, full}, 64'd0);
    drive_r(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20); tick(); tick();
    chk("t4_wc2", {61'h0, word_count}, 64'd2);
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_no_write", {63'h0, mem_we}, 64'd0);
    chk("t4_wc0", {61'h0, word_count}, 64'd0);
    drive_i(6'h08, 5'd4, 5'd5, 16'hFFFF); tick();
    chk("t4_addr0", {62'h0, mem_addr}, 64'd0);
    chk("t4_wc1", {61'h0, word_count}, 64'd1);
    chk("t4_data", {32'h0, mem_data}, 64'h2085FFFF);
    drive_r(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20); tick();
    chk("t4_addr1", {62'h0, mem_addr}, 64'd1);
    check_cs("t4_checksum", 32'h20A7E7DF);

    // async reset mid-load
    reset = 1'b0; #1;
    chk("t5_we",   {63'h0, mem_we}, 64'd0);
    chk("t5_addr", {62'h0, mem_addr}, 64'd0);
    chk("t5_data", {32'h0, mem_data}, 64'd0);
    chk("t5_wc",   {61'h0, word_count}, 64'd0);
    chk("t5_ready", {63'h0, in_ready}, 64'd0);
    check_cs("t5_cs", 32'h0);
    tick(); tick();
    chk("t5_we_held", {63'h0, mem_we}, 64'd0);
    reset = 1'b1; tick();
    chk("t5_idle_we", {63'h0, mem_we}, 64'd0);
    chk("t5_idle_ready", {63'h0, in_ready}, 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_start_nowrite", {63'h0, mem_we}, 64'd0);
    drive_i(6'h08, 5'd4, 5'd5, 16'hFFFF); tick();
    chk("t5_addr0", {62'h0, mem_addr}, 64'd0);
    chk("t5_we1", {63'h0, mem_we}, 64'd1);
    // NOP with HALT opcode is an all-zero word and does not stop the load
    fmt = 2'd3; operation = 6'h3F; tick(); in_valid = 1'b0;
    chk("t6_nop_data", {32'h0, mem_data}, 64'd0);
    chk("t6_nop_addr", {62'h0, mem_addr}, 64'd1);
    chk("t6_nop_done", {63'h0, done}, 64'd0);
    chk("t6_nop_ready", {63'h0, in_ready}, 64'd1);
    check_cs("t6_checksum", 32'h2085FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_packer.md
# instruction_packer

Sequential instruction assembler: the encoding counterpart of the pipeline's field splitter. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit MIPS words in R, I or J format. It writes each word to consecutive instruction-memory addresses and stops on a HALT opcode or when memory is full. It sits between the debug/loader front end and the instruction memory write port.

## Interface
- NB_DATA, 32, instruction word width
- NB_OP, 6, opcode field width
- NB_FUNCT, 6, funct field width
- NB_INM, 16, immediate field width
- NB_REG, 5, register-specifier and shamt width
- NB_DIRECTION, 26, jump target width
- NB_ADDR, 8, instruction-memory address width (depth 2^NB_ADDR words)
- HALT_OP, 6'h3F, opcode that terminates loading
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins or restarts a load at address 0
- in_valid  in  1  field tuple valid
- in_ready  out  1  packer can accept a tuple this cycle
- fmt  in  2  0=R, 1=I, 2=J, 3=NOP (all-zero word)
- operation  in  NB_OP  opcode
- funct  in  NB_FUNCT  R funct
- shamt  in  NB_REG  R shift amount
- wire_A  in  NB_REG  rs
- wire_B  in  NB_REG  rt
- wire_dest  in  NB_REG  rd
- inmediate  in  NB_INM  I immediate
- direction  in  NB_DIRECTION  J target
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  NB_ADDR  write address
- mem_data  out  NB_DATA  packed word
- word_count  out  NB_ADDR+1  words written since start
- done  out  1  load finished (HALT written or full)
- full  out  1  load finished because memory filled
- checksum  out  NB_DATA  XOR of written words (macro only)

## Operation
- States: IDLE, LOAD, DONE. Reset → IDLE.
- IDLE: in_ready=0. start → LOAD, and the write pointer is cleared.
- LOAD: in_ready=1. A tuple is accepted when in_valid&in_ready.
- Packing:
  - R = {operation, wire_A, wire_B, wire_dest, shamt, funct}
  - I = {operation, wire_A, wire_B, inmediate}
  - J = {operation, direction}
  - NOP = 32'h0. Unused fields are ignored.
- Each accepted tuple produces exactly one write at the pointer; the pointer then increments.
- Accepted word with operation==HALT_OP (fmt R/I/J; not NOP) → it is written, then LOAD→DONE.
- Accepted word at address 2^NB_ADDR−1 → it is written, then LOAD→DONE with full=1. If it is also HALT, full=1 still.
- DONE: in_ready=0, done=1. Outputs hold. start → LOAD and clears word_count, done, full and checksum.
- start during LOAD restarts at address 0. A tuple presented in the same cycle is not accepted (start has priority). A write registered in the previous cycle still completes.
- Reset asserted mid-load: all state is cleared immediately. No write strobe is produced after reset assertion.
- Output reset values: in_ready=0, mem_we=0, mem_addr=0, mem_data=0, word_count=0, done=0, full=0, checksum=0.

## Timing
- Latency: accept at edge N → mem_we=1 with mem_addr/mem_data valid during cycle N+1 (registered outputs). mem_we is a one-cycle pulse per word.
- Throughput: one word per cycle while in_valid stays high.
- in_ready drops in the cycle after the HALT or last-address accept. done/full rise in that same cycle, coincident with the final mem_we.
- in_ready rises the cycle after start.
- word_count updates together with mem_we.

## Configuration
- INSTR_PACKER_CHECKSUM_EN defined: checksum is a register, XORed with mem_data on each write and cleared on start/reset.
- Macro undefined: the checksum port is tied to 0 and no checksum logic is built.

## Test plan
- start, then R tuple (op 0, rs 1, rt 2, rd 3, shamt 0, funct 0x20) then J tuple (op HALT_OP, direction 0) → mem_data 0x00221820 @0, 0xFC000000 @1; done=1, full=0, word_count=2.
- I tuple (op 0x08, rs 4, rt 5, imm 0xFFFF) with in_valid held 3 cycles → addresses 0,1,2 on consecutive cycles, each word 0x2085FFFF.
- NB_ADDR=2, four non-HALT tuples → writes @0..3, then done=1, full=1, in_ready=0. A fifth in_valid is not accepted.
- start pulsed on the same cycle as the third tuple → that tuple is not written; next accepted tuple goes to address 0 and word_count=1.
- reset asserted mid-load after 2 writes → all outputs 0 immediately, state IDLE. The first load after a new start writes @0.
- With INSTR_PACKER_CHECKSUM_EN: words 0x00221820, 0x2085FFFF → checksum 0x20A7E7DF. Without the macro, checksum stays 0.
